sram_frame_streamer: RTL and testbench
======================================

# sram_frame_streamer

Reads a processed frame (e.g. the Gaussian-filtered image) out of an `sram_image` instance in raster order and emits it as a valid/ready pixel stream with line and frame markers. It is the read-side counterpart to the convolution write path. It sits between the conv SRAM and downstream consumers: the FAST corner stage, a DMA, or a bench dump. It hides the SRAM's 1-cycle read latency behind a 2-entry output buffer, so it sustains 1 pixel/cycle under full throughput and loses nothing under backpressure.

## Interface
Parameters:
- `X_MAX`, 400: maximum frame width.
- `Y_MAX`, 400: maximum frame height.
- `PIXEL_DEPTH`, 8: bits per pixel.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a frame when idle.
- `max_x`  in  $clog2(X_MAX)  frame width in pixels; latched on accepted `start`.
- `max_y`  in  $clog2(Y_MAX)  frame height in pixels; latched on accepted `start`.
- `x_addr`  out  $clog2(X_MAX)+1  SRAM column address.
- `y_addr`  out  $clog2(Y_MAX)+1  SRAM row address.
- `ren`  out  1  SRAM read enable.
- `rdat`  in  PIXEL_DEPTH  SRAM read data, valid the cycle after `ren`.
- `out_valid`  out  1  `out_pixel` and the marker outputs are valid.
- `out_ready`  in  1  consumer accepts the beat when high together with `out_valid`.
- `out_pixel`  out  PIXEL_DEPTH  pixel data.
- `out_sof`  out  1  beat is pixel (0,0).
- `out_eol`  out  1  beat has x == width-1.
- `out_eof`  out  1  beat is the last pixel of the frame.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
States:
- IDLE: waits for `start`. On an accepted start, latch width/height, clear the read and output counters, go to READ. If width==0 or height==0, go directly to DONE and issue no reads.
- READ: issue raster reads, x fastest, (0,0)..(w-1,h-1). After the last address is issued, go to DRAIN.
- DRAIN: no new reads. Wait until the buffer is empty and the in-flight read has landed; the eof beat must have been accepted. Then go to DONE.
- DONE: pulse `frame_done` for one cycle, return to IDLE.

Read issue rule:
- Issue a read when `occupancy + inflight - pop < 2`.
- `pop` = `out_valid & out_ready` this cycle.
- `inflight` = `ren` was high last cycle.
- The buffer therefore never overflows.

Buffer:
- 2-entry FIFO holding {pixel, sof, eol, eof}.
- Markers are computed from the issued coordinates and delayed alongside the read.
- `out_valid` = FIFO not empty.

Other rules:
- `out_pixel` and the markers hold stable while `out_valid & !out_ready`.
- `start` while `busy` is ignored. It does not restart the frame and does not relatch width/height.
- `x_addr`/`y_addr` hold their last value while `ren` is low; they do not drive X.
- Address wrap: at x==w-1, x→0 and y→y+1. No read is issued past (w-1,h-1).
- Counters are wide enough for X_MAX*Y_MAX beats; no wrap within a frame.

Reset (`rst` high, asynchronously):
- State goes to IDLE and the FIFO is cleared.
- `ren`, `out_valid`, all markers, `busy` and `frame_done` go to 0.
- `x_addr`, `y_addr` and `out_pixel` go to 0.
- A frame interrupted by reset is abandoned; no `frame_done` is issued for it.

## Timing
- Cycle 0: `start` is sampled high and the FSM enters READ. `busy` goes high in cycle 1.
- Cycle 1: `ren`=1 with address (0,0).
- Cycle 2: `rdat` is valid and is captured into the FIFO at the end of the cycle.
- Cycle 3: first `out_valid`=1 with `out_sof`=1.
- With `out_ready` held high, beats are continuous: w*h beats in w*h consecutive cycles from cycle 3.
- `frame_done` is high in the cycle after the eof handshake. `busy` drops in that same cycle.
- `start` may be accepted the cycle after `frame_done`.
- Backpressure of any length or pattern must not reorder, drop or duplicate pixels.

## Configuration
- Macro: `FRAME_STREAMER_CHECKSUM_EN`.
- Defined: adds output port `checksum` [15:0]. It is the sum of all accepted `out_pixel` values mod 2^16, cleared on accepted `start`, and valid and stable from `frame_done` until the next accepted `start`.
- Undefined: no port, no accumulator logic.

## Test plan
- 4x3 frame, SRAM holds value = 10*y+x, `out_ready`=1 → 12 beats on consecutive cycles 3..14: 0,1,2,3,10..13,20..23. `out_sof` on beat 0; `out_eol` on beats 3, 7, 11; `out_eof` on beat 11; `frame_done` in cycle 15.
- Same frame with pseudo-random `out_ready` (about 50%) → identical 12-value sequence. Data is stable while stalled, and `ren` is never issued while the FIFO plus in-flight read would exceed 2.
- width=0, height=5 → `ren` never asserted, no beats, `frame_done` pulses; a subsequent 2x2 frame streams normally.
- `start` re-pulsed mid-frame with different `max_x`/`max_y` → ignored; the original frame completes unchanged.
- `rst` asserted mid-frame (after 5 beats of a 4x3 frame) → all outputs 0 immediately, no `frame_done`; a fresh start then streams the full 12 beats.
- 400x242 frame written by the Gaussian convolution pass, streamed with `out_ready`=1 → stream matches the SRAM dump pixel for pixel. With `FRAME_STREAMER_CHECKSUM_EN`, `checksum` equals the bench-computed mod-2^16 sum.

Source files
------------

// File: rtl/sram_frame_streamer.sv
// Raster-order SRAM frame reader feeding a valid/ready pixel stream with sof/eol/eof markers; first beat 3 cycles after start, 1 pixel/cycle sustained.
// Backpressure: a 2-entry buffer absorbs the 1-cycle SRAM latency, and reads stall so nothing is lost. FRAME_STREAMER_CHECKSUM_EN adds a checksum port.
module sram_frame_streamer #(
    parameter int X_MAX       = 400,
    parameter int Y_MAX       = 400,
    parameter int PIXEL_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(X_MAX)-1:0]   max_x,
    input  logic [$clog2(Y_MAX)-1:0]   max_y,
    output logic [$clog2(X_MAX):0]     x_addr,
    output logic [$clog2(Y_MAX):0]     y_addr,
    output logic                       ren,
    input  logic [PIXEL_DEPTH-1:0]     rdat,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PIXEL_DEPTH-1:0]     out_pixel,
    output logic                       out_sof,
    output logic                       out_eol,
    output logic                       out_eof,
    output logic                       busy,
    output logic                       frame_done
`ifdef FRAME_STREAMER_CHECKSUM_EN
    ,
    output logic [15:0]                checksum
`endif
);
    localparam int XW = $clog2(X_MAX);
    localparam int YW = $clog2(Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [PIXEL_DEPTH-1:0] pix;
        logic                   sof;
        logic                   eol;
        logic                   eof;
    } beat_t;

    state_t        state_q, state_d;
    logic [XW-1:0] w_q, w_d;
    logic [YW-1:0] h_q, h_d;
    logic [XW:0]   x_q, x_d;
    logic [YW:0]   y_q, y_d;
    logic          inflight_q;
    logic [2:0]    meta_q;
    beat_t         fifo_q [2];
    logic          rd_ptr_q, wr_ptr_q;
    logic [1:0]    count_q;

    logic          pop, can_issue, last_x, last_y, start_acc;
    logic [2:0]    committed;
    beat_t         head;

    assign head      = fifo_q[rd_ptr_q];
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_pixel = head.pix;
    assign out_sof   = out_valid & head.sof;
    assign out_eol   = out_valid & head.eol;
    assign out_eof   = out_valid & head.eof;
    assign x_addr    = x_q;
    assign y_addr    = y_q;

    // Slots already spoken for after this cycle's pop: buffered beats plus the read in flight.
    assign committed = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign can_issue = (committed < 3'd2);
    assign last_x    = (x_q == ({1'b0, w_q} - {{XW{1'b0}}, 1'b1}));
    assign last_y    = (y_q == ({1'b0, h_q} - {{YW{1'b0}}, 1'b1}));

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        x_d        = x_q;
        y_d        = y_q;
        ren        = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        start_acc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    w_d       = max_x;
                    h_d       = max_y;
                    x_d       = '0;
                    y_d       = '0;
                    state_d   = (max_x == '0 || max_y == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                busy = 1'b1;
                if (can_issue) begin
                    ren = 1'b1;
                    // The final address is left on the bus; the counters stop there.
                    if (last_x && last_y) begin
                        state_d = S_DRAIN;
                    end else if (last_x) begin
                        x_d = '0;
                        y_d = y_q + {{YW{1'b0}}, 1'b1};
                    end else begin
                        x_d = x_q + {{XW{1'b0}}, 1'b1};
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (pop && head.eof) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            w_q        <= '0;
            h_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            inflight_q <= 1'b0;
            meta_q     <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            x_q        <= x_d;
            y_q        <= y_d;
            inflight_q <= ren;
            if (ren) begin
                meta_q <= {(x_q == '0) && (y_q == '0), last_x, last_x && last_y};
            end
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= beat_t'({rdat, meta_q});
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

`ifdef FRAME_STREAMER_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (start_acc) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_q + 16'(out_pixel);
        end
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_sram_frame_streamer.sv
// Bench for sram_frame_streamer: table of frame shapes plus reset/restart sequences, checked against a raster-order model of the SRAM contents.
module tb_sram_frame_streamer;
    localparam int XM = 400;
    localparam int YM = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [8:0] max_x = '0;
    logic [8:0] max_y = '0;
    logic [9:0] x_addr;
    logic [9:0] y_addr;
    logic       ren;
    logic [7:0] rdat = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_pixel;
    logic       out_sof, out_eol, out_eof, busy, frame_done;
`ifdef FRAME_STREAMER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    sram_frame_streamer #(.X_MAX(XM), .Y_MAX(YM), .PIXEL_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .max_x      (max_x),
        .max_y      (max_y),
        .x_addr     (x_addr),
        .y_addr     (y_addr),
        .ren        (ren),
        .rdat       (rdat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef FRAME_STREAMER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial forever #5 clk = ~clk;

    logic [7:0] sram [0:YM-1][0:XM-1];

    // SRAM model: one-cycle read latency
    always @(posedge clk) begin
        if (ren && int'(x_addr) < XM && int'(y_addr) < YM) begin
            rdat <= sram[y_addr][x_addr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fill(input int w, input int h, input int pat);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                sram[y][x] = (pat == 0) ? 8'((10 * y + x) % 256) : 8'($urandom);
            end
        end
    endtask

    task automatic run_frame(input int w, input int h, input int rmode, input bit timing,
                             input int rst_at, input int restart_at, output int beats);
        logic [10:0] exp_q[$];
        logic [10:0] beat, prev_beat;
        int  n, got, issued, outstanding, budget, sum;
        bit  done_seen, prev_stall, restarted, pop;
        n = w * h; got = 0; issued = 0; outstanding = 0; sum = 0;
        done_seen = 0; prev_stall = 0; restarted = 0; prev_beat = '0;
        budget = 6 * n + 40;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                exp_q.push_back({sram[y][x], (x == 0 && y == 0), (x == w - 1), (x == w - 1 && y == h - 1)});
            end
        end
        @(negedge clk);
        max_x = 9'(w);
        max_y = 9'(h);
        start = 1'b1;
        for (int c = 1; c <= budget && !done_seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (rst_at >= 0 && got == rst_at) begin
                rst = 1'b1;
                #1;
                chk({ren, out_valid, out_sof, out_eol, out_eof, busy, frame_done} == 7'd0,
                    "reset_ctrl", {ren, out_valid, out_sof, out_eol, out_eof, busy, frame_done}, 0);
                chk(x_addr == 10'd0 && y_addr == 10'd0 && out_pixel == 8'd0,
                    "reset_data", {x_addr, y_addr, out_pixel}, 0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
                out_ready = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    #1;
                    chk(!frame_done && !busy && !out_valid, "post_reset_idle", {frame_done, busy, out_valid}, 0);
                end
                beats = got;
                return;
            end
            if (c == 1) chk(busy == (n > 0), "busy_cycle1", busy, n > 0);
            beat = {out_pixel, out_sof, out_eol, out_eof};
            pop  = out_valid && out_ready;
            if (prev_stall) chk(out_valid && beat == prev_beat, "stall_hold", beat, prev_beat);
            if (ren) begin
                chk(issued < n, "ren_count", issued, n);
                chk(outstanding - int'(pop) + 1 <= 2, "ren_occupancy", outstanding - int'(pop) + 1, 2);
                if (w > 0) begin
                    chk(int'(x_addr) == issued % w, "x_addr", x_addr, issued % w);
                    chk(int'(y_addr) == issued / w, "y_addr", y_addr, issued / w);
                end
                issued++;
            end
            if (pop) begin
                if (got < n) chk(beat == exp_q[got], "beat_data", beat, exp_q[got]);
                else chk(1'b0, "extra_beat", got + 1, n);
                if (timing) chk(c == 3 + got, "beat_cycle", c, 3 + got);
                sum += int'(out_pixel);
                got++;
            end
            if (frame_done) begin
                done_seen = 1'b1;
                chk(got == n, "done_beats", got, n);
                chk(!busy, "busy_at_done", busy, 0);
                if (timing) chk(c == ((n > 0) ? 3 + n : 1), "done_cycle", c, (n > 0) ? 3 + n : 1);
`ifdef FRAME_STREAMER_CHECKSUM_EN
                chk(checksum == 16'(sum), "checksum", checksum, 16'(sum));
`endif
            end
            outstanding += int'(ren) - int'(pop);
            prev_stall = out_valid && !out_ready;
            prev_beat  = beat;
            if (restart_at >= 0 && got == restart_at && !restarted) begin
                restarted = 1'b1;
                start = 1'b1;
                max_x = 9'(w + 3);
                max_y = 9'(h + 2);
            end
        end
        if (!done_seen) begin
            chk(1'b0, "frame_timeout", got, n);
        end else begin
            @(negedge clk);
            #1;
            chk(!frame_done, "done_pulse_width", frame_done, 0);
        end
        beats = got;
    endtask

    typedef struct {
        int w;
        int h;
        int rmode;
        int pat;
        bit timing;
        int exp_beats;
    } vec_t;

    vec_t vecs[10];
    int   beats;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{w: 4,   h: 3,  rmode: 0, pat: 0, timing: 1, exp_beats: 12};
        vecs[1] = '{w: 4,   h: 3,  rmode: 1, pat: 0, timing: 0, exp_beats: 12};
        vecs[2] = '{w: 0,   h: 5,  rmode: 0, pat: 0, timing: 1, exp_beats: 0};
        vecs[3] = '{w: 2,   h: 2,  rmode: 0, pat: 1, timing: 1, exp_beats: 4};
        vecs[4] = '{w: 1,   h: 1,  rmode: 1, pat: 1, timing: 0, exp_beats: 1};
        vecs[5] = '{w: 7,   h: 0,  rmode: 0, pat: 0, timing: 1, exp_beats: 0};
        vecs[6] = '{w: 5,   h: 4,  rmode: 1, pat: 1, timing: 0, exp_beats: 20};
        vecs[7] = '{w: 1,   h: 6,  rmode: 0, pat: 1, timing: 1, exp_beats: 6};
        vecs[8] = '{w: 400, h: 40, rmode: 0, pat: 1, timing: 1, exp_beats: 16000};
        vecs[9] = '{w: 400, h: 3,  rmode: 1, pat: 1, timing: 0, exp_beats: 1200};

        repeat (3) @(negedge clk);
        #1;
        chk({ren, out_valid, out_sof, out_eol, out_eof, busy, frame_done} == 7'd0,
            "initial_reset_ctrl", {ren, out_valid, out_sof, out_eol, out_eof, busy, frame_done}, 0);
        chk(x_addr == 10'd0 && y_addr == 10'd0 && out_pixel == 8'd0, "initial_reset_data",
            {x_addr, y_addr, out_pixel}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            fill(vecs[i].w, vecs[i].h, vecs[i].pat);
            run_frame(vecs[i].w, vecs[i].h, vecs[i].rmode, vecs[i].timing, -1, -1, beats);
            chk(beats == vecs[i].exp_beats, "vector_beats", beats, vecs[i].exp_beats);
        end

        // start re-pulsed mid-frame with other dimensions must not disturb the frame
        fill(4, 3, 0);
        run_frame(4, 3, 1, 0, -1, 5, beats);
        chk(beats == 12, "restart_ignored_beats", beats, 12);

        // reset after 5 beats abandons the frame; a fresh frame then streams fully
        run_frame(4, 3, 0, 0, 5, -1, beats);
        chk(beats == 5, "reset_at_beat", beats, 5);
        run_frame(4, 3, 0, 1, -1, -1, beats);
        chk(beats == 12, "post_reset_frame_beats", beats, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
